// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Imported by hazard_detect and pipeline_hazard_ctrl.
package pipeline_pkg;

   localparam int REG_ADDR_W = 3;
   localparam int CNT_W      = 3;
   localparam int STAT_W     = 16;

   localparam logic [15:0] NOP_INSN = 16'h0000;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_write;
      logic halted;
   } ctrl_t;

   function automatic ctrl_t ctrl_run();
      ctrl_t c;
      c             = '0;
      c.pc_write    = 1'b1;
      c.if_id_write = 1'b1;
      c.id_ex_write = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by
// the instruction currently in ID.
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic                  op_mem_read_ex,
   input  logic [REG_ADDR_W-1:0] dst_ex,
   input  logic [REG_ADDR_W-1:0] src_a_id,
   input  logic [REG_ADDR_W-1:0] src_b_id,
   input  logic                  use_a_id,
   input  logic                  use_b_id,
   output logic                  load_use
);

   logic hit_a;
   logic hit_b;

   // Compare each used source against the load destination.
   always_comb begin
      hit_a    = use_a_id & (src_a_id == dst_ex);
      hit_b    = use_b_id & (src_b_id == dst_ex);
      load_use = op_mem_read_ex & (hit_a | hit_b);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: load-use stalls, branch flushes, HLT drain.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  op_mem_read_ex,
   input  logic [REG_ADDR_W-1:0] dst_ex,
   input  logic [REG_ADDR_W-1:0] src_a_id,
   input  logic [REG_ADDR_W-1:0] src_b_id,
   input  logic                  use_a_id,
   input  logic                  use_b_id,
   input  logic                  branch_taken_ex,
   input  logic                  halt_id,
   input  logic                  restart,
`ifdef HAZARD_STATS_EN
   output logic [STAT_W-1:0]     stall_count,
   output logic [STAT_W-1:0]     flush_count,
`endif
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  op_id_ex_write,
   output logic                  halted
);

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4) begin : g_bad_flush
      $error("FLUSH_CYCLES must be in 1..4");
   end
   if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 4) begin : g_bad_drain
      $error("DRAIN_CYCLES must be in 1..4");
   end

   localparam logic [CNT_W-1:0] FL_INIT = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] DR_INIT = CNT_W'(DRAIN_CYCLES);
   localparam logic             MULTI_FLUSH = (FLUSH_CYCLES > 1);

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   flush_cnt_q;
   logic [CNT_W-1:0]   flush_cnt_d;
   logic [CNT_W-1:0]   drain_cnt_q;
   logic [CNT_W-1:0]   drain_cnt_d;
   ctrl_t              ctrl;
   logic               load_use;
   logic               branch_ev;
   logic               stall_ev;

   hazard_detect u_hazard_detect (
      .op_mem_read_ex (op_mem_read_ex),
      .dst_ex         (dst_ex),
      .src_a_id       (src_a_id),
      .src_b_id       (src_b_id),
      .use_a_id       (use_a_id),
      .use_b_id       (use_b_id),
      .load_use       (load_use)
   );

   // State and counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // Next state, counters and stage enables from state and hazards.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      drain_cnt_d = drain_cnt_q;
      ctrl        = '0;
      branch_ev   = 1'b0;
      stall_ev    = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (branch_taken_ex) begin
               ctrl.pc_write    = 1'b1;
               ctrl.if_id_flush = 1'b1;
               branch_ev        = 1'b1;
               if (MULTI_FLUSH) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = FL_INIT;
               end
            end else if (halt_id) begin
               ctrl.id_ex_write = 1'b1;
               state_d          = ST_DRAIN;
               drain_cnt_d      = DR_INIT;
            end else if (load_use) begin
               stall_ev = 1'b1;
            end else begin
               ctrl = ctrl_run();
            end
         end
         ST_FLUSH: begin
            ctrl.pc_write    = 1'b1;
            ctrl.if_id_flush = 1'b1;
            flush_cnt_d      = flush_cnt_q - 1'b1;
            if (flush_cnt_q <= 3'd1) begin
               state_d     = ST_RUN;
               flush_cnt_d = '0;
            end
         end
         ST_DRAIN: begin
            drain_cnt_d = drain_cnt_q - 1'b1;
            if (drain_cnt_q <= 3'd1) begin
               state_d     = ST_HALTED;
               drain_cnt_d = '0;
            end
         end
         ST_HALTED: begin
            ctrl.halted = 1'b1;
            if (restart) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Outputs are forced low for as long as reset is held.
   always_comb begin
      pc_write       = ctrl.pc_write    & ~reset;
      if_id_write    = ctrl.if_id_write & ~reset;
      if_id_flush    = ctrl.if_id_flush & ~reset;
      op_id_ex_write = ctrl.id_ex_write & ~reset;
      halted         = ctrl.halted      & ~reset;
   end

`ifdef HAZARD_STATS_EN
   // Saturating event counters; one flush event per taken branch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_ev && stall_count != '1) begin
            stall_count <= stall_count + 1'b1;
         end
         if (branch_ev && flush_count != '1) begin
            flush_count <= flush_count + 1'b1;
         end
      end
   end
`else
   logic unused_ev;
   assign unused_ev = branch_ev ^ stall_ev;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with FLUSH_CYCLES=2.
// Expected enables are queued per cycle and checked on the falling edge.
module tb_pipeline_hazard_ctrl;
   import pipeline_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       op_mem_read_ex;
   logic [2:0] dst_ex;
   logic [2:0] src_a_id;
   logic [2:0] src_b_id;
   logic       use_a_id;
   logic       use_b_id;
   logic       branch_taken_ex;
   logic       halt_id;
   logic       restart;
   logic       pc_write;
   logic       if_id_write;
   logic       if_id_flush;
   logic       op_id_ex_write;
   logic       halted;
`ifdef HAZARD_STATS_EN
   logic [15:0] stall_count;
   logic [15:0] flush_count;
`endif

   pipeline_hazard_ctrl #(
      .FLUSH_CYCLES (2),
      .DRAIN_CYCLES (3)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .op_mem_read_ex  (op_mem_read_ex),
      .dst_ex          (dst_ex),
      .src_a_id        (src_a_id),
      .src_b_id        (src_b_id),
      .use_a_id        (use_a_id),
      .use_b_id        (use_b_id),
      .branch_taken_ex (branch_taken_ex),
      .halt_id         (halt_id),
      .restart         (restart),
`ifdef HAZARD_STATS_EN
      .stall_count     (stall_count),
      .flush_count     (flush_count),
`endif
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .op_id_ex_write  (op_id_ex_write),
      .halted          (halted)
   );

   always #5 clock = ~clock;

   // Expected bits: {pc_write, if_id_write, if_id_flush, id_ex_write, halted}
   typedef struct {
      string      name;
      logic [4:0] exp;
      logic [4:0] care;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   localparam logic [4:0] ALL  = 5'b11111;
   localparam logic [4:0] NOIW = 5'b10111;
   localparam logic [4:0] E_ZERO = 5'b00000;
   localparam logic [4:0] E_RUN  = 5'b11010;
   localparam logic [4:0] E_FL   = 5'b10100;
   localparam logic [4:0] E_HLT  = 5'b00010;
   localparam logic [4:0] E_HALT = 5'b00001;

   // Monitor: pop one expectation per falling edge and compare.
   always @(negedge clock) begin
      exp_t e;
      logic [4:0] act;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         act = {pc_write, if_id_write, if_id_flush,
                op_id_ex_write, halted};
         n_checks++;
         if ((act & e.care) == (e.exp & e.care)) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got %b expected %b (mask %b)",
                     e.name, act, e.exp, e.care);
         end
      end
   end

   task automatic step(input string nm,
                       input logic rst, input logic mr,
                       input logic [2:0] d, input logic [2:0] sa,
                       input logic [2:0] sb, input logic ua,
                       input logic ub, input logic br,
                       input logic hl, input logic rs,
                       input logic [4:0] e, input logic [4:0] m);
      exp_t x;
      @(posedge clock);
      #1;
      reset           = rst;
      op_mem_read_ex  = mr;
      dst_ex          = d;
      src_a_id        = sa;
      src_b_id        = sb;
      use_a_id        = ua;
      use_b_id        = ub;
      branch_taken_ex = br;
      halt_id         = hl;
      restart         = rs;
      x.name = nm;
      x.exp  = e;
      x.care = m;
      exp_q.push_back(x);
   endtask

   task automatic idle(input string nm, input logic [4:0] e);
      step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e, ALL);
   endtask

`ifdef HAZARD_STATS_EN
   task automatic chk_stat(input string nm, input logic [15:0] act,
                           input logic [15:0] exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask
`endif

   initial begin
      reset = 1'b1;
      op_mem_read_ex = 0; dst_ex = 0; src_a_id = 0; src_b_id = 0;
      use_a_id = 0; use_b_id = 0; branch_taken_ex = 0;
      halt_id = 0; restart = 0;

      step("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_ZERO, ALL);
      step("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_ZERO, ALL);
      idle("run_after_reset", E_RUN);

      step("lu_a_stall", 0, 1, 2, 2, 0, 1, 0, 0, 0, 0, E_ZERO, ALL);
      idle("lu_a_resume", E_RUN);
      step("lu_b_unused", 0, 1, 2, 3, 2, 1, 0, 0, 0, 0, E_RUN, ALL);
      step("lu_b_stall", 0, 1, 2, 3, 2, 1, 1, 0, 0, 0, E_ZERO, ALL);
      step("lu_noload", 0, 0, 2, 2, 2, 1, 1, 0, 0, 0, E_RUN, ALL);

      step("br1_c1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FL, NOIW);
      step("br1_c2_rebr", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FL, NOIW);
      idle("br1_done", E_RUN);

      step("br_halt_lu", 0, 1, 4, 4, 0, 1, 0, 1, 1, 0, E_FL, NOIW);
      step("br_halt_c2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FL, NOIW);
      idle("br_halt_done", E_RUN);

      step("halt_id", 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, E_HLT, ALL);
      step("drain1_br", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_ZERO, ALL);
      step("drain2_rs", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_ZERO, ALL);
      idle("drain3", E_ZERO);
      idle("halted1", E_HALT);
      idle("halted2", E_HALT);
      step("restart", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_HALT, ALL);
      idle("after_restart", E_RUN);
      step("restart_in_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, ALL);
      idle("run_again", E_RUN);

`ifdef HAZARD_STATS_EN
      @(negedge clock);
      chk_stat("stall_count", stall_count, 16'd2);
      chk_stat("flush_count", flush_count, 16'd2);
`endif

      step("halt2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_HLT, ALL);
      idle("halt2_drain1", E_ZERO);
      step("rst_drain2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_ZERO, ALL);
      step("rst_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_ZERO, ALL);
      idle("rst_release", E_RUN);
      idle("rst_release2", E_RUN);

`ifdef HAZARD_STATS_EN
      @(negedge clock);
      chk_stat("stall_after_rst", stall_count, 16'd0);
      chk_stat("flush_after_rst", flush_count, 16'd0);
`endif

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(posedge clock);
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain_queue: got %0d pending expected 0",
                  exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX). Detects load-use hazards, branch-taken flushes and HLT, and drives the per-stage write/flush enables. ID/EX clears to a bubble whenever its write enable is 0, so this block injects bubbles by deasserting op_id_ex_write. State is registered; the enables are combinational from state and current-cycle hazard inputs.

Parameters:
FLUSH_CYCLES, 1, cycles of IF/ID flush + ID/EX bubble per taken branch (legal 1..4)
DRAIN_CYCLES, 3, cycles after HLT leaves ID until the pipeline is empty (EX, MEM, WB)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op_mem_read_ex  in  1  instruction in EX is a load
dst_ex  in  3  destination register of the instruction in EX
src_a_id  in  3  first source register of the instruction in ID
src_b_id  in  3  second source register of the instruction in ID
use_a_id  in  1  ID instruction reads src_a_id
use_b_id  in  1  ID instruction reads src_b_id
branch_taken_ex  in  1  branch in EX resolved taken this cycle
halt_id  in  1  HLT decoded in ID
restart  in  1  one-cycle pulse, leave HALTED
pc_write  out  1  PC loads next value
if_id_write  out  1  IF/ID captures fetched instruction
if_id_flush  out  1  IF/ID loads NOP (overrides if_id_write)
op_id_ex_write  out  1  1 = ID/EX captures, 0 = bubble
halted  out  1  pipeline fully stopped

Behaviour:
- Reset (async, high): state=RUN, flush_cnt=0, drain_cnt=0; while reset is high: pc_write=0, if_id_write=0, if_id_flush=0, op_id_ex_write=0, halted=0.
- States: RUN, FLUSH, DRAIN, HALTED (2-bit encoding).
- load_use = op_mem_read_ex & ((use_a_id & src_a_id==dst_ex) | (use_b_id & src_b_id==dst_ex)).
- RUN priority: branch_taken_ex > halt_id > load_use > normal.
  - branch_taken_ex: pc_write=1, if_id_flush=1, op_id_ex_write=0. If FLUSH_CYCLES>1: go to FLUSH with flush_cnt=FLUSH_CYCLES-1; otherwise stay in RUN. halt_id and load_use are ignored, because the ID instruction is being killed.
  - halt_id: pc_write=0, if_id_write=0, op_id_ex_write=1 (HLT proceeds to EX). Go to DRAIN with drain_cnt=DRAIN_CYCLES.
  - load_use: pc_write=0, if_id_write=0, op_id_ex_write=0, one cycle. The next cycle EX holds a bubble, so load_use self-clears without extra state.
  - normal: pc_write=if_id_write=op_id_ex_write=1, if_id_flush=0.
- FLUSH: pc_write=1, if_id_flush=1, op_id_ex_write=0. flush_cnt decrements each cycle; return to RUN when flush_cnt reaches 1 on the current cycle. branch_taken_ex inside FLUSH is ignored, because EX holds a bubble.
- DRAIN: pc_write=0, if_id_write=0, op_id_ex_write=0. drain_cnt decrements each cycle; go to HALTED when it reaches 1. branch_taken_ex is ignored, because HLT is not a branch and older branches already resolved.
- HALTED: all enables 0, halted=1. restart → RUN on the next edge, with normal enables from that cycle. restart is ignored in any other state.
- Reset mid-FLUSH or mid-DRAIN: returns immediately to RUN with counters cleared.
- Counters are 3 bits wide; FLUSH_CYCLES and DRAIN_CYCLES above 4 are illegal (elaboration-time check).

Optional Feature:
HAZARD_STATS_EN — adds outputs stall_count[15:0] and flush_count[15:0]. stall_count increments on each load_use stall cycle; flush_count increments on each taken-branch event, counted once per branch and not per flush cycle. Both saturate at 16'hFFFF and clear on reset. Without the macro, these ports and their logic are absent.

Decomposition:
- Shared package pipeline_pkg: state enum (ST_RUN, ST_FLUSH, ST_DRAIN, ST_HALTED), REG_ADDR_W=3, NOP instruction constant.
- Load-use comparator as sub-module hazard_detect (pure combinational).
- FSM and counters stay in the top module.

Test Plan:
- Load R2 in EX (dst_ex=2, op_mem_read_ex=1), ID reads src_a_id=2 with use_a_id=1 → exactly one cycle with pc_write=0, if_id_write=0, op_id_ex_write=0, then all 1.
- Same load, but src_a_id=3 and src_b_id=2 with use_b_id=0 → no stall; all enables remain 1.
- branch_taken_ex pulse with FLUSH_CYCLES=2 → 2 consecutive cycles of if_id_flush=1, op_id_ex_write=0, pc_write=1; a second branch_taken_ex in cycle 2 has no effect.
- branch_taken_ex and halt_id in the same cycle → flush wins; state stays out of DRAIN; halted stays 0.
- halt_id → 1 cycle with op_id_ex_write=1, then 3 drain cycles, then halted=1; restart pulse → halted=0 and enables 1 on the next cycle.
- Assert reset during the 2nd DRAIN cycle → all outputs 0 immediately; after reset deasserts, state is RUN with enables 1. With HAZARD_STATS_EN, counters read 0.
